// File: rtl/snn_result_streamer_pkg.sv
// Shared types and default sizes for the SNN result streamer.
// The beat struct is the FIFO payload; the state enum is the streamer FSM.
package snn_pkg;
  localparam int DEF_T = 4;
  localparam int DEF_N = 8;
  localparam int DW    = 32;
  localparam int UW    = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [UW-1:0] blk;
    logic          last;
  } snn_beat_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} streamer_state_t;

  // Address widths stay at least 1 bit so T=1 / N=1 builds keep real ports.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/snn_result_streamer_fifo.sv
// Small registered FIFO with a registered head word; push and pop may coincide.
// Kept free of streamer types so the input-side block can reuse it.
module axis_skid_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic                    do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/snn_result_streamer.sv
// Streams every neuron state word (block-major) out of the state RAM as AXI-S beats.
// Reads are credit-limited so the 2-entry FIFO can never overflow under backpressure.
module snn_result_streamer import snn_pkg::*; #(
  parameter  int T  = DEF_T,
  parameter  int N  = DEF_N,
  localparam int BW = clog2_min1(T),
  localparam int NW = clog2_min1(N)
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          start,
  output logic          rd_en,
  output logic [BW-1:0] rd_block,
  output logic [NW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic [DW-1:0] m_tdata,
  output logic [UW-1:0] m_tuser,
  output logic          m_tlast,
  output logic          busy,
  output logic          done
);
  streamer_state_t state, state_nxt;
  logic [BW-1:0]   blk;
  logic [NW-1:0]   nrn;
  logic            inflight, tag_last, last_addr, pop;
  logic [UW-1:0]   tag_blk;
  logic [1:0]      fifo_count;
  logic [2:0]      credit;
  logic            fifo_empty, fifo_full;
  snn_beat_t       wbeat, head;

  assign last_addr = (blk == BW'(T - 1)) && (nrn == NW'(N - 1));
  assign pop       = m_tvalid && m_tready;
  // Counting the slot freed by this cycle's pop keeps 1 beat/cycle with tready high.
  assign credit    = 3'(fifo_count) - 3'(pop) + 3'(inflight);
  assign rd_en     = (state == RUN) && (credit < 3'd2) && !(fifo_full && !pop);
  assign rd_block  = blk;
  assign rd_addr   = nrn;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (rd_en && last_addr) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && head.last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters wrap back to 0 after the final read, so the next dump starts clean.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      blk      <= '0;
      nrn      <= '0;
      inflight <= 1'b0;
      tag_blk  <= '0;
      tag_last <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (rd_en) begin
        tag_blk  <= UW'(blk);
        tag_last <= last_addr;
        if (nrn == NW'(N - 1)) begin
          nrn <= '0;
          blk <= (blk == BW'(T - 1)) ? '0 : blk + 1'b1;
        end else begin
          nrn <= nrn + 1'b1;
        end
      end
    end
  end

  always_comb begin
    wbeat      = '0;
    wbeat.data = rd_data;
    wbeat.blk  = tag_blk;
    wbeat.last = tag_last;
  end

  axis_skid_fifo #(.W($bits(snn_beat_t)), .DEPTH(2)) u_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (inflight),
    .din   (wbeat),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign m_tvalid = !fifo_empty;
  assign m_tdata  = head.data;
  assign m_tuser  = head.blk;
  assign m_tlast  = head.last;
endmodule

// File: tb/tb_snn_result_streamer.sv
// Scoreboard bench: stimulus queues expected beats, negedge monitors pop and compare.
// Covers a 4x8 build and a 1x1 build side by side.
module tb_snn_result_streamer;
  import snn_pkg::*;

  typedef struct {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic          last;
  } exp_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic start = 1'b0, start1 = 1'b0, tready = 1'b0;
  always #5 aclk = ~aclk;

  logic          rd_en, tvalid, tlast, busy, done;
  logic [1:0]    rd_block;
  logic [2:0]    rd_addr;
  logic [DW-1:0] rd_data = '0, tdata;
  logic [UW-1:0] tuser;
  logic          rd_en1, tvalid1, tlast1, busy1, done1;
  logic          rd_block1, rd_addr1;
  logic [DW-1:0] rd_data1 = '0, tdata1;
  logic [UW-1:0] tuser1;

  snn_result_streamer #(.T(4), .N(8)) u_dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .rd_en(rd_en), .rd_block(rd_block),
    .rd_addr(rd_addr), .rd_data(rd_data), .m_tvalid(tvalid), .m_tready(tready),
    .m_tdata(tdata), .m_tuser(tuser), .m_tlast(tlast), .busy(busy), .done(done));

  snn_result_streamer #(.T(1), .N(1)) u_dut1 (
    .aclk(aclk), .aresetn(aresetn), .start(start1), .rd_en(rd_en1), .rd_block(rd_block1),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .m_tvalid(tvalid1), .m_tready(tready),
    .m_tdata(tdata1), .m_tuser(tuser1), .m_tlast(tlast1), .busy(busy1), .done(done1));

  int checks = 0, errors = 0, beats = 0, dones = 0, dones1 = 0, rds = 0;
  exp_t exp_q[$], exp1_q[$];
  bit rand_mode = 0, poke_done = 0;

  function automatic logic [DW-1:0] pat(input int b, input int n);
    return 32'hA500_0000 | DW'(b << 8) | DW'(n);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // State RAM model: data valid exactly one cycle after the read strobe.
  always @(posedge aclk) begin
    rd_data  <= rd_en  ? pat(int'(rd_block), int'(rd_addr))   : 32'hDEAD_BEEF;
    rd_data1 <= rd_en1 ? pat(int'(rd_block1), int'(rd_addr1)) : 32'hDEAD_BEEF;
  end

  logic          prev_stall = 1'b0, prev_lhs = 1'b0, prev_lhs1 = 1'b0;
  logic [DW-1:0] prev_d = '0;

  always @(negedge aclk) begin
    exp_t e;
    if (!aresetn) begin
      prev_stall = 1'b0;
      prev_lhs   = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(tvalid), 64'd1);
        chk("hold_data", 64'(tdata), 64'(prev_d));
      end
      if (done || prev_lhs) chk("done_timing", 64'(done), 64'(prev_lhs));
      if (done) dones++;
      if (rd_en) rds++;
      if (u_dut.u_fifo.full)
        chk("no_overflow", 64'(u_dut.u_fifo.push && !u_dut.u_fifo.pop), 64'd0);
      if (tvalid && tready) begin
        beats++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got tdata=%0h, required no beat", tdata);
        end else begin
          e = exp_q.pop_front();
          chk("tdata", 64'(tdata), 64'(e.data));
          chk("tuser", 64'(tuser), 64'(e.user));
          chk("tlast", 64'(tlast), 64'(e.last));
        end
      end
      prev_stall = tvalid && !tready;
      prev_d     = tdata;
      prev_lhs   = tvalid && tready && tlast;
    end
  end

  always @(negedge aclk) begin
    exp_t e;
    if (!aresetn) prev_lhs1 = 1'b0;
    else begin
      if (done1 || prev_lhs1) chk("done1_timing", 64'(done1), 64'(prev_lhs1));
      if (done1) dones1++;
      if (tvalid1 && tready) begin
        if (exp1_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat1: got tdata=%0h, required no beat", tdata1);
        end else begin
          e = exp1_q.pop_front();
          chk("tdata1", 64'(tdata1), 64'(e.data));
          chk("tuser1", 64'(tuser1), 64'(e.user));
          chk("tlast1", 64'(tlast1), 64'(e.last));
        end
      end
      prev_lhs1 = tvalid1 && tready && tlast1;
    end
  end

  // Re-pulse start during the done cycle; it must be ignored.
  always @(negedge aclk) begin
    if (poke_done && done) begin
      poke_done = 0;
      start = 1'b1;
      @(posedge aclk); #1;
      start = 1'b0;
    end
  end

  task automatic tick();
    @(posedge aclk); #1;
    if (rand_mode) tready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_dump();
    for (int b = 0; b < 4; b++)
      for (int n = 0; n < 8; n++)
        exp_q.push_back('{pat(b, n), UW'(b), (b == 3 && n == 7)});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, output int cyc);
    cyc = 0;
    while (dones == d0 && cyc < 3000) begin
      tick();
      cyc++;
    end
    chk("done_seen", 64'(dones - d0), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cyc, d0, r0, b0, s;
    tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out", 64'({tdata, tuser, tlast}), 64'd0);
    aresetn = 1'b1;
    tick(); tick();

    // Full-rate dump with latency checks.
    push_dump(); d0 = dones; r0 = rds;
    pulse_start();
    chk("c1_rd_en", 64'(rd_en), 64'd1);
    chk("c1_addr", 64'({rd_block, rd_addr}), 64'd0);
    chk("c1_busy", 64'(busy), 64'd1);
    chk("c1_tvalid", 64'(tvalid), 64'd0);
    tick(); chk("c2_tvalid", 64'(tvalid), 64'd0);
    tick(); chk("c3_tvalid", 64'(tvalid), 64'd1);
    wait_done(d0, cyc);
    chk("stream_cycles", 64'(cyc), 64'd33);
    tick();
    chk("reads", 64'(rds - r0), 64'd32);
    chk("idle_busy", 64'(busy), 64'd0);

    // Random backpressure.
    s = $urandom(32'd2024);
    rand_mode = 1;
    push_dump(); d0 = dones;
    pulse_start();
    wait_done(d0, cyc);
    rand_mode = 0; tready = 1'b1;
    tick();
    chk("rand_queue", 64'(exp_q.size()), 64'd0);

    // Long stall right after start.
    tready = 1'b0;
    push_dump(); d0 = dones; r0 = rds;
    pulse_start();
    repeat (100) tick();
    chk("bp_reads", 64'(rds - r0), 64'd2);
    chk("bp_tvalid", 64'(tvalid), 64'd1);
    chk("bp_tdata", 64'(tdata), 64'(pat(0, 0)));
    tready = 1'b1;
    wait_done(d0, cyc);
    chk("bp_queue", 64'(exp_q.size()), 64'd0);
    tick();

    // Reset in the middle of a dump.
    push_dump(); d0 = dones; b0 = beats;
    pulse_start();
    for (int k = 0; k < 200 && beats - b0 < 13; k++) tick();
    chk("beat13_reached", 64'(beats - b0), 64'd13);
    #2 aresetn = 1'b0;
    #1;
    chk("mid_rst_tvalid", 64'(tvalid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_rd_en", 64'(rd_en), 64'd0);
    exp_q.delete();
    repeat (3) tick();
    chk("mid_rst_no_done", 64'(dones - d0), 64'd0);
    aresetn = 1'b1;
    tick();
    push_dump(); d0 = dones;
    pulse_start();
    chk("restart_rd_en", 64'(rd_en), 64'd1);
    chk("restart_addr", 64'({rd_block, rd_addr}), 64'd0);
    wait_done(d0, cyc);
    chk("restart_cycles", 64'(cyc), 64'd35);
    tick();

    // Stray start pulses mid-dump and on the done cycle.
    push_dump(); d0 = dones; r0 = rds;
    pulse_start();
    repeat (10) tick();
    pulse_start();
    poke_done = 1;
    wait_done(d0, cyc);
    repeat (10) tick();
    chk("ign_dones", 64'(dones - d0), 64'd1);
    chk("ign_reads", 64'(rds - r0), 64'd32);
    chk("ign_busy", 64'(busy), 64'd0);
    chk("ign_queue", 64'(exp_q.size()), 64'd0);

    // T=1, N=1 build: a single beat.
    exp1_q.push_back('{pat(0, 0), '0, 1'b1});
    d0 = dones1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("s_rd_en", 64'(rd_en1), 64'd1);
    cyc = 0;
    while (dones1 == d0 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("s_done", 64'(dones1 - d0), 64'd1);
    chk("s_cycles", 64'(cyc), 64'd4);
    chk("s_queue", 64'(exp1_q.size()), 64'd0);
    tick();
    chk("s_busy", 64'(busy1), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
